// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access unit.
//   size_e   : access width as encoded by the control unit
//   state_e  : sequencer states
//   BE_*     : unshifted byte-enable patterns for each access width
//   decode_size   : folds the reserved size code onto a word access
//   is_misaligned : alignment rule applied in the CHECK state
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    ACCESS = 3'd2,
    DONE   = 3'd3,
    ERR_MA = 3'd4,
    ERR_TO = 3'd5
  } state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Size code 2'b11 is not defined by the ISA encoding; treat it as a word.
  function automatic size_e decode_size(input logic [1:0] sz);
    case (sz)
      2'b00:   decode_size = SZ_BYTE;
      2'b01:   decode_size = SZ_HALF;
      default: decode_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: is_misaligned = lo[0];
      SZ_WORD: is_misaligned = (lo != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering between the CPU view (byte address + size)
// and the word-organised memory.
// Ports:
//   size_i      : access width (size_e encoding)
//   addr_lo_i   : byte offset within the word
//   sign_ext_i  : 1 = sign-extend narrow loads
//   wdata_i     : store data from register B
//   mem_rdata_i : raw word returned by memory
//   be_o        : byte enables for the addressed lanes
//   wdata_o     : store data replicated into every lane
//   rdata_o     : selected load lane, right-justified and extended
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        sign_ext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign byte_lane[gi] = mem_rdata_i[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half_lane
      assign half_lane[gi] = mem_rdata_i[16*gi +: 16];
    end
  endgenerate

  assign byte_sel = byte_lane[addr_lo_i];
  assign half_sel = half_lane[addr_lo_i[1]];

  always_comb begin
    be_o    = BE_WORD;
    wdata_o = wdata_i;
    rdata_o = mem_rdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o    = BE_BYTE << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be_o    = BE_HALF << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sign_ext_i & half_sel[15]}}, half_sel};
      end
      default: begin
        be_o    = BE_WORD;
        wdata_o = wdata_i;
        rdata_o = mem_rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access sequencer between the IorD address mux and a word-organised
// memory with variable wait states.
// Ports:
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   rd_req, wr_req        : requests from the control unit (write wins)
//   addr, wdata           : byte address and store data
//   size, sign_ext        : access width and load extension mode
//   rdata                 : last completed load, aligned and extended
//   busy                  : high whenever not IDLE; requests are ignored
//   done                  : one-cycle completion pulse
//   misalign_err          : one-cycle pulse, request rejected before memory
//   timeout_err           : one-cycle pulse, memory never became ready
//   mem_addr/wdata/be     : word address, replicated data, byte enables
//   mem_re, mem_we        : strobes, only in ACCESS
//   mem_rdata, mem_ready  : memory response
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        misalign_err,
  output logic        timeout_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  size_e             size_q, size_d;
  logic              sext_q, sext_d;
  logic              wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_rdata;

  mem_lane_align u_lane (
    .size_i      (size_q),
    .addr_lo_i   (addr_q[1:0]),
    .sign_ext_i  (sext_q),
    .wdata_i     (wdata_q),
    .mem_rdata_i (mem_rdata),
    .be_o        (lane_be),
    .wdata_o     (lane_wdata),
    .rdata_o     (lane_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_BYTE;
      sext_q  <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    sext_d  = sext_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;

    busy         = 1'b1;
    done         = 1'b0;
    misalign_err = 1'b0;
    timeout_err  = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_be       = '0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (rd_req || wr_req) begin
          addr_d  = addr;
          wdata_d = wdata;
          size_d  = decode_size(size);
          sext_d  = sign_ext;
          wr_d    = wr_req;
          state_d = CHECK;
        end
      end
      CHECK: begin
        cnt_d   = '0;
        state_d = is_misaligned(size_q, addr_q[1:0]) ? ERR_MA : ACCESS;
      end
      ACCESS: begin
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wdata = lane_wdata;
        mem_be    = lane_be;
        mem_re    = ~wr_q;
        mem_we    = wr_q;
        // Ready is honoured even on the last permitted wait cycle.
        if (mem_ready) begin
          state_d = DONE;
          if (!wr_q) begin
            rdata_d = lane_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = ERR_TO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR_MA: begin
        misalign_err = 1'b1;
        state_d      = IDLE;
      end
      ERR_TO: begin
        timeout_err = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rdata = rdata_q;

endmodule
